// File: rtl/mux_scan_n.sv
// Registered N:1 channel multiplexer with manual select or a masked round-robin
// scanner that dwells a fixed number of accepted samples per channel.
// Output side is a single valid/ready register; all outputs come from flops.
module mux_scan_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS-1:0]       mask,
  input  logic                      en,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
  output logic                      dout_valid
);

  logic [SEL_W-1:0] ptr;
  logic [7:0]       dwell_cnt;
  logic             mode_q;

  logic             slot_free;
  logic             entry;
  logic             scan_hit;
  logic [SEL_W-1:0] scan_tgt;
  logic             man_legal;
  logic [SEL_W-1:0] tgt;
  logic             legal;
  logic             load;
  logic [WIDTH-1:0] tgt_word;
  logic [7:0]       cnt_now;
  logic [SEL_W-1:0] ptr_adv;

  assign slot_free = !dout_valid || out_ready;
  // Switching into scan only re-arms the scanner; sampling starts one edge later.
  assign entry     = mode && !mode_q;
  assign man_legal = int'(sel_in) < CHANNELS;

  // Circular search for the first unmasked channel at or after ptr. Walking the
  // offsets downward leaves the smallest matching offset as the final winner.
  always_comb begin
    int idx;
    idx      = 0;
    scan_tgt = '0;
    scan_hit = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (mask[idx]) begin
        scan_tgt = SEL_W'(idx);
        scan_hit = 1'b1;
      end
    end
  end

  assign tgt   = mode ? scan_tgt : sel_in;
  assign legal = mode ? (scan_hit && !entry) : man_legal;
  assign load  = slot_free && en && legal;

  // Word mux by comparison so an out-of-range select never indexes past din.
  always_comb begin
    tgt_word = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (SEL_W'(k) == tgt) tgt_word = din[k*WIDTH +: WIDTH];
  end

  // A fresh channel restarts the dwell count with this sample as the first.
  assign cnt_now = (tgt != ptr) ? 8'd1 : dwell_cnt + 8'd1;
  assign ptr_adv = (int'(tgt) == CHANNELS - 1) ? '0 : tgt + SEL_W'(1);

  // Output register: capture on load, drop valid on an empty free slot, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      mode_q <= mode;
      if (slot_free) begin
        if (load) begin
          dout       <= tgt_word;
          dout_ch    <= tgt;
          dout_valid <= 1'b1;
        end else begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

  // Scanner state: re-armed on mode entry, advanced only by scan-mode loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      dwell_cnt <= '0;
    end else if (entry) begin
      ptr       <= '0;
      dwell_cnt <= '0;
    end else if (load && mode) begin
      if (cnt_now >= 8'(DWELL)) begin
        ptr       <= ptr_adv;
        dwell_cnt <= '0;
      end else begin
        ptr       <= tgt;
        dwell_cnt <= cnt_now;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: expected output triples are queued before each
// edge and popped for comparison one time unit after it.
module tb_mux_scan_n;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  // Main instance: 16 channels, dwell of 2.
  logic [127:0]  din;
  logic          mode, en, out_ready;
  logic [3:0]    sel_in;
  logic [15:0]   mask;
  logic [7:0]    dout;
  logic [3:0]    dout_ch;
  logic          dout_valid;

  // Second instance: 12 channels, for select range checking.
  logic [95:0]   din12;
  logic          mode12, en12, ready12;
  logic [3:0]    sel12;
  logic [11:0]   mask12;
  logic [7:0]    dout12;
  logic [3:0]    ch12;
  logic          valid12;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [3:0] ch;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(8), .CHANNELS(16), .SEL_W(4), .DWELL(2)) u_dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in), .mask(mask),
    .en(en), .out_ready(out_ready), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid)
  );

  mux_scan_n #(.WIDTH(8), .CHANNELS(12), .SEL_W(4), .DWELL(1)) u_dut12 (
    .clk(clk), .rst(rst), .din(din12), .mode(mode12), .sel_in(sel12), .mask(mask12),
    .en(en12), .out_ready(ready12), .dout(dout12), .dout_ch(ch12),
    .dout_valid(valid12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected post-edge output, run one edge, then pop and compare.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] ch, input string tag);
    exp_t e;
    e.v = v; e.d = d; e.ch = ch;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e.v));
    chk({tag, ".dout"},  32'(dout),       32'(e.d));
    chk({tag, ".ch"},    32'(dout_ch),    32'(e.ch));
  endtask

  initial begin
    int seq [18] = '{0,0,1,1,2,2,3,3,8,8,9,9,10,10,11,11,0,0};

    for (int k = 0; k < 16; k++) din[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 12; k++) din12[k*8 +: 8] = 8'(8'h40 + k);
    mode = 1'b0; sel_in = 4'd5; mask = 16'h0000; en = 1'b1; out_ready = 1'b1;
    mode12 = 1'b0; sel12 = 4'd13; mask12 = 12'hFFF; en12 = 1'b1; ready12 = 1'b1;

    // Reset state
    #2;
    chk("reset.valid", 32'(dout_valid), 32'd0);
    chk("reset.dout",  32'(dout),       32'd0);
    chk("reset.ch",    32'(dout_ch),    32'd0);
    rst = 1'b0;

    // T1: manual select of channel 5
    step(1'b1, 8'h15, 4'd5, "t1");

    // T2: backpressure holds the word while the select changes
    out_ready = 1'b0; sel_in = 4'd9;
    step(1'b1, 8'h15, 4'd5, "t2.hold0");
    step(1'b1, 8'h15, 4'd5, "t2.hold1");
    step(1'b1, 8'h15, 4'd5, "t2.hold2");
    out_ready = 1'b1;
    step(1'b1, 8'h19, 4'd9, "t2.release");

    // T3: enter scan (entry edge loads nothing), then dwell 2 per unmasked channel
    mode = 1'b1; mask = 16'h0F0F;
    step(1'b0, 8'h19, 4'd9, "t3.entry");
    for (int i = 0; i < 18; i++)
      step(1'b1, 8'(8'h10 + seq[i]), 4'(seq[i]), $sformatf("t3.s%0d", i));

    // T4: empty mask drops valid; pointer holds at 1 for the next search
    mask = 16'h0000;
    step(1'b0, 8'h10, 4'd0, "t4.empty");
    mask = 16'hFFFF;
    step(1'b1, 8'h11, 4'd1, "t4.ptr_held");
    mask = 16'h8000;
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'h1F, 4'd15, $sformatf("t4.only15_%0d", i));

    // en low with backpressure: word waits, then valid falls on ready
    en = 1'b0; out_ready = 1'b0;
    step(1'b1, 8'h1F, 4'd15, "en_off.hold");
    out_ready = 1'b1;
    step(1'b0, 8'h1F, 4'd15, "en_off.drain");

    // T6: load channel 8 under backpressure, then pulse reset mid-cycle
    en = 1'b1; mask = 16'h0F00; out_ready = 1'b0;
    step(1'b1, 8'h18, 4'd8, "t6.load");
    step(1'b1, 8'h18, 4'd8, "t6.hold");
    #3;
    rst = 1'b1;
    #1;
    chk("t6.rst.valid", 32'(dout_valid), 32'd0);
    chk("t6.rst.dout",  32'(dout),       32'd0);
    chk("t6.rst.ch",    32'(dout_ch),    32'd0);
    rst = 1'b0; out_ready = 1'b1;
    step(1'b0, 8'h00, 4'd0, "t6.entry");
    step(1'b1, 8'h18, 4'd8, "t6.s0");
    step(1'b1, 8'h18, 4'd8, "t6.s1");
    step(1'b1, 8'h19, 4'd9, "t6.s2");

    // T5: 12-channel instance rejects select 13, accepts 11
    @(posedge clk); #1;
    chk("t5.sel13.valid", 32'(valid12), 32'd0);
    sel12 = 4'd11;
    @(posedge clk); #1;
    chk("t5.sel11.valid", 32'(valid12), 32'd1);
    chk("t5.sel11.ch",    32'(ch12),    32'd11);
    chk("t5.sel11.dout",  32'(dout12),  32'h4B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
